// File: rtl/btn_evt_pkg.sv
// Shared types for the button event controller.
//   NUM_BUTTONS : button count the event record is sized for
//   IDW         : width of a button index
//   btn_evt_t   : one queued event, {button index, press flag}
// The event record width follows NUM_BUTTONS, so a different button
// count is set here and then picked up as the top-level default.
package btn_evt_pkg;

    localparam int NUM_BUTTONS = 4;
    localparam int IDW         = $clog2(NUM_BUTTONS);

    typedef struct packed {
        logic [IDW-1:0] id;
        logic           press;
    } btn_evt_t;

endpackage

// File: rtl/btn_channel.sv
// Synchronizer plus tick-driven debouncer for one raw button input.
//   Clk, Reset  : system clock, synchronous active-high reset
//   tick        : shared sample strobe, one cycle wide
//   btn         : raw asynchronous level
//   stable      : debounced level
//   edge_pulse  : one-cycle strobe on the cycle stable flips
//   edge_type   : new stable level, valid while edge_pulse is high
module btn_channel #(
    parameter int STABLE_CNT = 4
) (
    input  logic Clk,
    input  logic Reset,
    input  logic tick,
    input  logic btn,
    output logic stable,
    output logic edge_pulse,
    output logic edge_type
);

    // cnt only ever holds 0..STABLE_CNT-1
    localparam int CW = (STABLE_CNT > 1) ? $clog2(STABLE_CNT) : 1;

    logic          sync1_q;
    logic          sync_q;
    logic          stable_q, stable_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        stable_d   = stable_q;
        cnt_d      = cnt_q;
        edge_pulse = 1'b0;
        if (tick) begin
            if (sync_q == stable_q) begin
                cnt_d = '0;
            end else if (cnt_q == CW'(STABLE_CNT - 1)) begin
                // this tick is the STABLE_CNT-th differing one
                stable_d   = ~stable_q;
                cnt_d      = '0;
                edge_pulse = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            sync1_q  <= 1'b0;
            sync_q   <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= btn;
            sync_q   <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable    = stable_q;
    assign edge_type = ~stable_q;

endmodule

// File: rtl/button_event_ctrl.sv
// Multi-button controller: debounces N raw inputs on a shared sample tick,
// turns debounced edges into press/release events, drains them round-robin
// into a small FIFO read through valid/ready, and flags lost events.
//   Clk, Reset          : system clock, synchronous active-high reset
//   btn_in              : raw button levels, 1 = pressed
//   state_o             : debounced levels
//   evt_valid/evt_ready : FIFO head handshake
//   evt_id, evt_press   : head event (button index, 1 = press)
//   overflow, ovf_clr   : sticky lost-event flag and its clear
module button_event_ctrl
    import btn_evt_pkg::*;
#(
    parameter int N_BUTTONS  = NUM_BUTTONS,
    parameter int TICK_DIV   = 50000,
    parameter int STABLE_CNT = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                         Clk,
    input  logic                         Reset,
    input  logic [N_BUTTONS-1:0]         btn_in,
    output logic [N_BUTTONS-1:0]         state_o,
    output logic                         evt_valid,
    input  logic                         evt_ready,
    output logic [$clog2(N_BUTTONS)-1:0] evt_id,
    output logic                         evt_press,
    output logic                         overflow,
    input  logic                         ovf_clr
);

    localparam int TW = $clog2(TICK_DIV);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
    logic                 tick;

    logic [N_BUTTONS-1:0] stable_w;
    logic [N_BUTTONS-1:0] edge_pulse_w;
    logic [N_BUTTONS-1:0] edge_type_w;

    logic [N_BUTTONS-1:0] pend_q, pend_d;
    logic [N_BUTTONS-1:0] ptype_q, ptype_d;
    logic [IDW-1:0]       rr_ptr_q, rr_ptr_d;
    logic                 overflow_q, overflow_d;
    logic                 ovf_set;

    logic                 grant_vld;
    logic [IDW-1:0]       grant_id;
    int                   idx;

    btn_evt_t             mem_q [FIFO_DEPTH];
    btn_evt_t             mem_d [FIFO_DEPTH];
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        count_q, count_d;
    logic                 fifo_full;
    logic                 push, pop;

    // Sample tick
    assign tick       = (tick_cnt_q == TW'(TICK_DIV - 1));
    assign tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);

    for (genvar g = 0; g < N_BUTTONS; g++) begin : g_chan
        btn_channel #(
            .STABLE_CNT (STABLE_CNT)
        ) u_chan (
            .Clk        (Clk),
            .Reset      (Reset),
            .tick       (tick),
            .btn        (btn_in[g]),
            .stable     (stable_w[g]),
            .edge_pulse (edge_pulse_w[g]),
            .edge_type  (edge_type_w[g])
        );
    end

    // Fullness is taken from the registered count, so a pop in the same
    // cycle never makes room for a push.
    assign fifo_full = (count_q == CW'(FIFO_DEPTH));

    // Round-robin: first pending channel at or after rr_ptr+1, wrapping.
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = '0;
        idx       = 0;
        if (!fifo_full) begin
            for (int k = 1; k <= N_BUTTONS; k++) begin
                idx = (int'(rr_ptr_q) + k) % N_BUTTONS;
                if (!grant_vld && pend_q[idx]) begin
                    grant_vld = 1'b1;
                    grant_id  = IDW'(idx);
                end
            end
        end
    end

    // Pending events; a new edge beats a same-cycle grant clear. An edge
    // landing on a pend that is not being drained this cycle loses the
    // older event.
    always_comb begin
        pend_d   = pend_q;
        ptype_d  = ptype_q;
        rr_ptr_d = rr_ptr_q;
        ovf_set  = 1'b0;
        if (grant_vld) begin
            pend_d[grant_id] = 1'b0;
            rr_ptr_d         = grant_id;
        end
        for (int i = 0; i < N_BUTTONS; i++) begin
            if (edge_pulse_w[i]) begin
                if (pend_q[i] && !(grant_vld && grant_id == IDW'(i))) begin
                    ovf_set = 1'b1;
                end
                pend_d[i]  = 1'b1;
                ptype_d[i] = edge_type_w[i];
            end
        end
        overflow_d = ovf_set | (overflow_q & ~ovf_clr);
    end

    // Event FIFO
    assign push = grant_vld;
    assign pop  = (count_q != '0) && evt_ready;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);
        if (push) begin
            mem_d[wr_ptr_q].id    = grant_id;
            mem_d[wr_ptr_q].press = ptype_q[grant_id];
            wr_ptr_d              = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            tick_cnt_q <= '0;
            pend_q     <= '0;
            ptype_q    <= '0;
            rr_ptr_q   <= IDW'(N_BUTTONS - 1);
            overflow_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            tick_cnt_q <= tick_cnt_d;
            pend_q     <= pend_d;
            ptype_q    <= ptype_d;
            rr_ptr_q   <= rr_ptr_d;
            overflow_q <= overflow_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            mem_q      <= mem_d;
        end
    end

    assign state_o   = stable_w;
    assign evt_valid = (count_q != '0);
    assign evt_id    = mem_q[rd_ptr_q].id;
    assign evt_press = mem_q[rd_ptr_q].press;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_button_event_ctrl.sv
// Bench for button_event_ctrl with a 4-cycle tick and 3-tick debounce.
// Expected events go into a queue as buttons are driven; a negedge monitor
// pops and compares them as the DUT hands them over.
module tb_button_event_ctrl;

    localparam int NB = 4;
    localparam int TD = 4;
    localparam int SC = 3;
    localparam int FD = 4;

    logic          Clk = 1'b0;
    logic          Reset = 1'b1;
    logic [NB-1:0] btn_in = '0;
    logic          evt_ready = 1'b0;
    logic          ovf_clr = 1'b0;
    logic [NB-1:0] state_o;
    logic          evt_valid;
    logic [1:0]    evt_id;
    logic          evt_press;
    logic          overflow;

    int n_chk = 0;
    int n_err = 0;
    int exp_q[$];       // encoded as id*2 + press
    int tick_ph = 0;    // bench's view of sample-tick phase, for aligning stimulus

    always #5 Clk = ~Clk;

    button_event_ctrl #(
        .N_BUTTONS  (NB),
        .TICK_DIV   (TD),
        .STABLE_CNT (SC),
        .FIFO_DEPTH (FD)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .btn_in    (btn_in),
        .state_o   (state_o),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_id    (evt_id),
        .evt_press (evt_press),
        .overflow  (overflow),
        .ovf_clr   (ovf_clr)
    );

    always @(posedge Clk) begin
        if (Reset) tick_ph <= 0;
        else       tick_ph <= (tick_ph == TD - 1) ? 0 : tick_ph + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor: a handshake seen at negedge completes on the next posedge.
    always @(negedge Clk) begin
        int e;
        if (!Reset && evt_valid && evt_ready) begin
            if (exp_q.size() == 0) begin
                check_eq("evt_unexp", exp_q.size(), 1);
            end else begin
                e = exp_q.pop_front();
                check_eq("evt_id", evt_id, e / 2);
                check_eq("evt_press", evt_press, e % 2);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    // Leaves us just after an edge that restarted the tick counter, so the
    // next ticks land 4, 8 and 12 edges later.
    task automatic align();
        do step(1); while (tick_ph != 0);
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        step(2);
        Reset = 1'b0;
        exp_q.delete();
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 60; i++) begin
            @(negedge Clk);
            if (exp_q.size() == 0) break;
        end
        check_eq(tag, exp_q.size(), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        int chg;

        // Reset values
        step(3);
        @(negedge Clk);
        check_eq("rst_valid", evt_valid, 0);
        check_eq("rst_state", state_o, 0);
        check_eq("rst_id", evt_id, 0);
        check_eq("rst_press", evt_press, 0);
        check_eq("rst_ovf", overflow, 0);
        Reset = 1'b0;

        // 1. Clean press on button 2
        evt_ready = 1'b1;
        align();
        btn_in[2] = 1'b1;
        exp_q.push_back(2 * 2 + 1);
        n = 0;
        while (n < 40) begin
            @(negedge Clk);
            if (state_o[2]) break;
            n++;
        end
        check_eq("t1_latency", n, 12);
        check_eq("t1_valid_at_e", evt_valid, 0);
        @(negedge Clk);
        check_eq("t1_valid_e1", evt_valid, 1);
        wait_drain("t1_drain");
        align();
        btn_in[2] = 1'b0;
        exp_q.push_back(2 * 2 + 0);
        wait_drain("t1_rel_drain");
        check_eq("t1_rel_state", state_o, 0);

        // 2. Glitch of two ticks on button 1
        align();
        btn_in[1] = 1'b1;
        step(8);
        btn_in[1] = 1'b0;
        chg = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge Clk);
            if (state_o != 0) chg++;
        end
        check_eq("t2_state_chg", chg, 0);
        check_eq("t2_valid", evt_valid, 0);

        // 3. Simultaneous press from a fresh reset (rr_ptr = 3)
        do_reset();
        align();
        btn_in = 4'hF;
        for (int i = 0; i < NB; i++) exp_q.push_back(i * 2 + 1);
        n = 0;
        while (n < 40) begin
            @(negedge Clk);
            if (state_o != 0) break;
            n++;
        end
        check_eq("t3_state_all", state_o, 4'hF);
        check_eq("t3_valid_at_e", evt_valid, 0);
        for (int i = 0; i < NB; i++) begin
            @(negedge Clk);
            check_eq("t3_valid_run", evt_valid, 1);
        end
        @(negedge Clk);
        check_eq("t3_valid_end", evt_valid, 0);
        check_eq("t3_drained", exp_q.size(), 0);
        align();
        btn_in = 4'h0;
        for (int i = 0; i < NB; i++) exp_q.push_back(i * 2);
        wait_drain("t3_rel_drain");

        // 4. Backpressure and overflow
        evt_ready = 1'b0;
        align();
        btn_in = 4'hF;
        for (int i = 0; i < NB; i++) exp_q.push_back(i * 2 + 1);
        step(16);
        @(negedge Clk);
        check_eq("t4_valid", evt_valid, 1);
        check_eq("t4_head_id", evt_id, 0);
        check_eq("t4_head_press", evt_press, 1);
        check_eq("t4_ovf0", overflow, 0);
        align();
        btn_in[0] = 1'b0;
        step(13);
        @(negedge Clk);
        check_eq("t4_rel_state", state_o, 4'hE);
        check_eq("t4_ovf_stuck", overflow, 0);
        check_eq("t4_head_hold", evt_id, 0);
        align();
        btn_in[0] = 1'b1;
        step(13);
        @(negedge Clk);
        check_eq("t4_ovf_set", overflow, 1);
        check_eq("t4_press_state", state_o, 4'hF);
        step(5);
        @(negedge Clk);
        check_eq("t4_ovf_sticky", overflow, 1);
        check_eq("t4_head_press_hold", evt_press, 1);
        ovf_clr = 1'b1;
        step(1);
        ovf_clr = 1'b0;
        @(negedge Clk);
        check_eq("t4_ovf_clr", overflow, 0);
        align();
        btn_in[0] = 1'b0;
        step(11);
        ovf_clr = 1'b1;
        step(1);
        ovf_clr = 1'b0;
        @(negedge Clk);
        check_eq("t4_ovf_setclr", overflow, 1);
        check_eq("t4_rel2_state", state_o, 4'hE);
        check_eq("t4_head_final", evt_id, 0);

        // 5. Full FIFO plus single pop, colliding with a new edge on the stuck channel
        ovf_clr = 1'b1;
        step(1);
        ovf_clr = 1'b0;
        @(negedge Clk);
        check_eq("t5_ovf_pre", overflow, 0);
        align();
        btn_in[0] = 1'b1;
        step(11);
        evt_ready = 1'b1;
        step(1);
        evt_ready = 1'b0;
        @(negedge Clk);
        // pop freed a slot but the grant waits a cycle, so the pending
        // release is overwritten by the press and counts as lost
        check_eq("t5_ovf_at_pop", overflow, 1);
        exp_q.push_back(0 * 2 + 1);
        evt_ready = 1'b1;
        wait_drain("t5_drain");
        check_eq("t5_state", state_o, 4'hF);

        // 6. Reset mid-operation
        evt_ready = 1'b0;
        align();
        btn_in[3:1] = 3'b000;
        step(16);
        @(negedge Clk);
        check_eq("t6_queued", evt_valid, 1);
        align();
        btn_in[0] = 1'b0;
        step(5);
        Reset = 1'b1;
        step(1);
        Reset = 1'b0;
        exp_q.delete();
        @(negedge Clk);
        check_eq("t6_valid", evt_valid, 0);
        check_eq("t6_state", state_o, 0);
        check_eq("t6_ovf", overflow, 0);
        check_eq("t6_id", evt_id, 0);
        evt_ready = 1'b1;
        align();
        btn_in[0] = 1'b1;
        exp_q.push_back(0 * 2 + 1);
        wait_drain("t6_drain");
        step(30);
        @(negedge Clk);
        check_eq("t6_idle", evt_valid, 0);
        check_eq("t6_final_state", state_o, 4'h1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
